// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding,
// iteration count, operation codes and the operand magnitude helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    ON       = 2'd2,
    END      = 2'd3
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [5:0] LAST_STEP = 6'(DIV_WIDTH - 1);

  // ALU control codes routed to this unit by the decoder
  localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one shift/subtract step per cycle, producing
// {remainder, quotient} with a single-cycle ready pulse.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        ready
);

  div_state_t  state, state_next;
  logic [31:0] a_q, b_q;
  logic        signed_q;
  logic [64:0] acc;
  logic [5:0]  cnt;

  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic [64:0] acc_src, shifted, acc_step;
  logic [32:0] diff;
  logic [31:0] quot, rem, quot_final, rem_final;

  assign accept = (state == IDLE) && start && !annul;
  assign ready  = (state == END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // annul overrides every transition, including a start seen in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = (b == 32'd0) ? DIV_ZERO : ON;
      DIV_ZERO: state_next = END;
      ON:       if (cnt == LAST_STEP) state_next = END;
      END:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (annul) state_next = IDLE;
  end

  // The first step seeds the partial remainder from the latched dividend,
  // so operands only need to be captured once at acceptance.
  always_comb begin
    a_mag      = magnitude(a_q, signed_q);
    b_mag      = magnitude(b_q, signed_q);
    acc_src    = (cnt == 6'd0) ? {33'd0, a_mag} : acc;
    shifted    = {acc_src[63:0], 1'b0};
    diff       = shifted[64:32] - {1'b0, b_mag};
    acc_step   = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};
    quot       = acc_step[31:0];
    rem        = acc_step[63:32];
    quot_final = (signed_q && (a_q[31] ^ b_q[31])) ? (~quot + 32'd1) : quot;
    rem_final  = (signed_q && a_q[31]) ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      signed_q <= signed_div;
      acc      <= '0;
      cnt      <= '0;
    end else if (state == ON && !annul) begin
      acc <= acc_step;
      cnt <= cnt + 6'd1;
      if (cnt == LAST_STEP) result <= {rem_final, quot_final};
    end else if (state == DIV_ZERO && !annul) begin
      result <= 64'h0;
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the divider: expected results are queued at issue
// time and compared, together with latency, when ready pulses.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          checks = 0;
  int          errors = 0;

  div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic sd);
    longint ma, mb, q, r;
    if (y == 32'd0) return 64'h0;
    if (sd) begin
      ma = longint'($signed(x));
      mb = longint'($signed(y));
    end else begin
      ma = longint'({32'd0, x});
      mb = longint'({32'd0, y});
    end
    q = ma / mb;
    r = ma % mb;
    return {r[31:0], q[31:0]};
  endfunction

  // Leaves the caller just after the accepting edge with start dropped and
  // the operand buses scrambled, which the busy divider must ignore.
  task automatic apply_stimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                                input logic sd);
    @(negedge clk);
    a          = op_a;
    b          = op_b;
    signed_div = sd;
    start      = 1'b1;
    exp_q.push_back(model(op_a, op_b, sd));
    lat_q.push_back((op_b == 32'd0) ? 1 : 32);
    @(posedge clk);
    #1;
    start      = 1'b0;
    a          = $urandom;
    b          = $urandom;
    signed_div = ~sd;
  endtask

  task automatic collect_result(input string tag);
    int k;
    int exp_lat;
    logic [63:0] exp_res;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) break;
    end
    exp_lat = lat_q.pop_front();
    exp_res = exp_q.pop_front();
    check_output({tag, " latency"}, 64'(k), 64'(exp_lat));
    check_output({tag, " result"}, result, exp_res);
    @(posedge clk);
    #1;
    check_output({tag, " ready drop"}, 64'(ready), 64'd0);
  endtask

  task automatic watch_no_ready(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check_output({tag, " no ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rs;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    #1;
    check_output("reset ready", 64'(ready), 64'd0);
    check_output("reset result", result, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    apply_stimulus(32'd100, 32'd7, 1'b0);
    collect_result("udiv 100/7");
    apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
    collect_result("sdiv -7/2");
    apply_stimulus(32'h1234, 32'd0, 1'b0);
    collect_result("div by zero");

    // abort mid-operation: result must keep the divide-by-zero value
    held = result;
    apply_stimulus(32'd100, 32'd7, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    watch_no_ready("annul");
    check_output("annul result held", result, held);
    apply_stimulus(32'd9, 32'd3, 1'b0);
    collect_result("udiv 9/3");

    apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    collect_result("sdiv min/-1");
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
    collect_result("udiv max/1");
    apply_stimulus(32'd7, 32'hFFFF_FFFF, 1'b0);
    collect_result("udiv 7/max");
    apply_stimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
    collect_result("sdiv 7/-2");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      rs = i[1];
      if (rb == 32'd0) rb = 32'd3;
      apply_stimulus(ra, rb, rs);
      collect_result($sformatf("random %0d", i));
    end

    // reset in the middle of an operation clears everything immediately
    apply_stimulus(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("midop reset ready", 64'(ready), 64'd0);
    check_output("midop reset result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    watch_no_ready("after reset");
    check_output("after reset result", result, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
